led_pattern_seq: RTL and testbench

//   Generates the on/off LED drive pattern for the fsm-lock status LED: off, steady, slow blink,

---
 rtl/led_pattern_seq_if.sv | 9 +
 rtl/led_pattern_seq.sv | 88 ++++++++
 tb/tb_led_pattern_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: mode/burst control in, LED enable and busy status out
interface led_pattern_seq_if;
    logic [1:0] mode;
    logic       burst_req;
    logic       data_out;
    logic       busy;
    modport master (output mode, burst_req, input data_out, busy);
    modport slave (input mode, burst_req, output data_out, busy);
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: status LED on/off pattern (off, steady, slow/fast blink) with one-shot flash bursts
module led_pattern_seq #(
    parameter int TICK_DIV    = 100000,
    parameter int SLOW_HALF   = 500,
    parameter int FAST_HALF   = 100,
    parameter int FLASH_HALF  = 150,
    parameter int FLASH_COUNT = 3
) (
    input logic clk,
    input logic rst_n,
    led_pattern_seq_if.slave bus
);
    localparam int MAX_HALF = SLOW_HALF > FAST_HALF ? (SLOW_HALF > FLASH_HALF ? SLOW_HALF : FLASH_HALF)
                                                    : (FAST_HALF > FLASH_HALF ? FAST_HALF : FLASH_HALF);
    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(MAX_HALF) + 1;
    localparam int CW = $clog2(FLASH_COUNT) + 1;
    typedef enum logic [1:0] {PATTERN, BURST_ON, BURST_OFF} state_t;
    state_t        state;
    logic [PW-1:0] pre;
    logic [HW-1:0] ph;
    logic [HW-1:0] half;
    logic [CW-1:0] cnt;
    logic [1:0]    mode_q;
    logic          phase;
    logic          tick;
    logic          ph_end;
    always_comb begin
        tick   = pre == PW'(TICK_DIV - 1);
        half   = state != PATTERN ? HW'(FLASH_HALF) : bus.mode[0] ? HW'(FAST_HALF) : HW'(SLOW_HALF);
        ph_end = tick && ph == half - 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PATTERN;
            pre          <= '0;
            ph           <= '0;
            cnt          <= '0;
            mode_q       <= 2'b00;
            phase        <= 1'b0;
            bus.data_out <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            mode_q <= bus.mode;
            pre    <= tick ? '0 : pre + 1'b1;
            ph     <= ph_end ? '0 : tick ? ph + 1'b1 : ph;
            case (state)
                PATTERN:
                    if (bus.burst_req) begin
                        state        <= BURST_ON;
                        bus.busy     <= 1'b1;
                        bus.data_out <= 1'b1;
                        cnt          <= '0;
                        pre          <= '0;
                        ph           <= '0;
                    end else if (bus.mode != mode_q) begin
                        pre          <= '0;
                        ph           <= '0;
                        phase        <= 1'b1;
                        bus.data_out <= |bus.mode;
                    end else begin
                        phase        <= phase ^ ph_end;
                        bus.data_out <= bus.mode[1] ? phase ^ ph_end : bus.mode[0];
                    end
                BURST_ON:
                    if (ph_end) begin
                        state        <= BURST_OFF;
                        bus.data_out <= 1'b0;
                    end
                BURST_OFF:
                    if (ph_end && cnt == CW'(FLASH_COUNT - 1)) begin
                        // leaving the burst restarts the pattern exactly like a mode change
                        state        <= PATTERN;
                        bus.busy     <= 1'b0;
                        pre          <= '0;
                        ph           <= '0;
                        phase        <= 1'b1;
                        bus.data_out <= |bus.mode;
                    end else if (ph_end) begin
                        state        <= BURST_ON;
                        cnt          <= cnt + 1'b1;
                        bus.data_out <= 1'b1;
                    end
                default: state <= PATTERN;
            endcase
        end
    end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed plus randomized checks against a time-arithmetic LED model
module tb_led_pattern_seq;
    localparam int TICK_DIV    = 4;
    localparam int SLOW_HALF   = 3;
    localparam int FAST_HALF   = 1;
    localparam int FLASH_HALF  = 2;
    localparam int FLASH_COUNT = 2;
    localparam int BURST_LEN   = 2 * FLASH_COUNT * FLASH_HALF * TICK_DIV;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    led_pattern_seq_if bus();
    led_pattern_seq #(
        .TICK_DIV(TICK_DIV),
        .SLOW_HALF(SLOW_HALF),
        .FAST_HALF(FAST_HALF),
        .FLASH_HALF(FLASH_HALF),
        .FLASH_COUNT(FLASH_COUNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    bit m_burst = 0;
    int m_b = 0;
    int m_t = 0;
    logic [1:0] m_mode = 2'b00;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic exp_data();
        if (m_burst) return (m_b / (FLASH_HALF * TICK_DIV)) % 2 == 0;
        if (m_mode == 2'b00) return 1'b0;
        if (m_mode == 2'b01) return 1'b1;
        return (m_t / ((m_mode == 2'b11 ? FAST_HALF : SLOW_HALF) * TICK_DIV)) % 2 == 0;
    endfunction
    task automatic model_reset();
        m_burst = 0;
        m_b = 0;
        m_t = 0;
        m_mode = 2'b00;
    endtask
    task automatic model_edge();
        if (!rst_n) model_reset();
        else if (m_burst) begin
            m_mode = bus.mode;
            m_b++;
            if (m_b == BURST_LEN) begin
                m_burst = 0;
                m_t = 0;
            end
        end else if (bus.burst_req) begin
            m_burst = 1;
            m_b = 0;
            m_mode = bus.mode;
        end else if (bus.mode != m_mode) begin
            m_mode = bus.mode;
            m_t = 0;
        end else m_t++;
    endtask
    task automatic step(input logic [1:0] md, input logic req, input string tag);
        bus.mode = md;
        bus.burst_req = req;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check({tag, ".data"}, 32'(bus.data_out), 32'(exp_data()));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_burst));
    endtask
    initial begin
        int n;
        bus.mode = 2'b01;
        bus.burst_req = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b01, 1'b0, "reset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(2'b01, 1'b0, "steady");
        for (int i = 0; i < 30; i++) step(2'b10, 1'b0, "slow");
        for (int i = 0; i < 20; i++) step(2'b11, 1'b0, "fast");
        for (int i = 0; i < 16; i++) step(2'b10, 1'b0, "slow2");
        for (int i = 0; i < 12; i++) step(2'b11, 1'b0, "switch");
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, "off");
        n = 0;
        step(2'b00, 1'b1, "burst");
        n += int'(bus.busy);
        for (int i = 0; i < 40; i++) begin
            step(2'b00, 1'b0, "burst");
            n += int'(bus.busy);
        end
        check("burst_len", 32'(n), 32'(BURST_LEN));
        n = 0;
        step(2'b00, 1'b1, "burst2");
        n += int'(bus.busy);
        for (int i = 0; i < 40; i++) begin
            step(i >= 15 ? 2'b01 : 2'b00, i == 9, "burst2");
            n += int'(bus.busy);
        end
        check("burst2_len", 32'(n), 32'(BURST_LEN));
        step(2'b10, 1'b1, "burst3");
        for (int i = 0; i < 12; i++) step(2'b10, 1'b0, "burst3");
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.data", 32'(bus.data_out), 32'd0);
        check("async_rst.busy", 32'(bus.busy), 32'd0);
        model_reset();
        @(negedge clk);
        step(2'b10, 1'b0, "in_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step(2'b10, 1'b0, "post_rst");
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] md;
            md = $urandom_range(0, 15) == 0 ? 2'($urandom_range(0, 3)) : bus.mode;
            step(md, $urandom_range(0, 29) == 0, "rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
